aes_encipher_round_ctrl: RTL and testbench

//  Iterative AES-128 encryption datapath. Sits directly downstream of aes_key_gen:
//  - drives its round index.
//  - consumes round_key and key_ready.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_round_mix.sv | 27 ++
 rtl/aes_encipher_round_ctrl.sv | 144 ++++++++++++++
 tb/tb_aes_encipher_round_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and GF(2^8) column/row helpers used by
// the key generator and the encipher datapath.
package aes_pkg;

   localparam logic [3:0] NUM_ROUNDS = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_SUB  = 2'd2,
      ST_MIX  = 2'd3
   } enc_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Row r of the state rotates left by r byte positions.
   function automatic logic [127:0] shift_rows(input logic [127:0] st);
      logic [127:0] res;
      res = 128'd0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            res[127-8*(4*c+r) -: 8] = st[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return res;
   endfunction

   function automatic logic [31:0] get_column(input logic [127:0] st, input logic [1:0] idx);
      logic [31:0] col;
      case (idx)
         2'd0:    col = st[127:96];
         2'd1:    col = st[95:64];
         2'd2:    col = st[63:32];
         2'd3:    col = st[31:0];
         default: col = 32'd0;
      endcase
      return col;
   endfunction

   function automatic logic [127:0] set_column(input logic [127:0] st, input logic [1:0] idx,
                                               input logic [31:0] col);
      logic [127:0] res;
      res = st;
      case (idx)
         2'd0:    res[127:96] = col;
         2'd1:    res[95:64]  = col;
         2'd2:    res[63:32]  = col;
         2'd3:    res[31:0]   = col;
         default: res = st;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/aes_round_mix.sv
// Combinational round tail: ShiftRows, MixColumns (bypassed on the last round)
// and AddRoundKey applied to a state whose bytes have already been substituted.
module aes_round_mix
   import aes_pkg::*;
(
   input  logic [127:0] st_i,
   input  logic [127:0] round_key_i,
   input  logic         final_round_i,
   output logic [127:0] mixed_o
);

   logic [127:0] shifted_s;
   logic [127:0] mixcol_s;

   // ShiftRows, optional MixColumns, then key addition
   always_comb begin
      shifted_s = shift_rows(st_i);
      mixcol_s  = {mix_column(shifted_s[127:96]), mix_column(shifted_s[95:64]),
                   mix_column(shifted_s[63:32]),  mix_column(shifted_s[31:0])};
      if (final_round_i) begin
         mixed_o = shifted_s ^ round_key_i;
      end else begin
         mixed_o = mixcol_s ^ round_key_i;
      end
   end

endmodule

// File: rtl/aes_encipher_round_ctrl.sv
// Iterative AES-128 encipher: one column per cycle through the external S-box,
// then the whole round tail in one cycle; aborts whenever the key store drops.
module aes_encipher_round_ctrl
   import aes_pkg::*;
(
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         key_ready,
   output logic [3:0]   round,
   input  logic [127:0] round_key,
   input  logic         start,
   input  logic [127:0] block,
   output logic         ready,
   output logic [127:0] result,
   output logic         result_valid,
   output logic [31:0]  sbox_feed,
   input  logic [31:0]  new_sbox
);

   enc_state_e   state_q, state_d;
   logic [3:0]   round_q, round_d;
   logic [1:0]   wcnt_q, wcnt_d;
   logic [127:0] st_q, st_d;
   logic [127:0] blk_q, blk_d;
   logic [127:0] result_q, result_d;
   logic         result_valid_q, result_valid_d;
   logic         ready_q, ready_d;
   logic [31:0]  feed_q, feed_d;
   logic [127:0] init_s;
   logic [127:0] mix_s;
   logic         final_round_s;

   assign init_s        = blk_q ^ round_key;
   assign final_round_s = (round_q == NUM_ROUNDS);

   aes_round_mix u_round_mix (
      .st_i          (st_q),
      .round_key_i   (round_key),
      .final_round_i (final_round_s),
      .mixed_o       (mix_s)
   );

   // Next-state logic for the round sequencer and datapath registers
   always_comb begin
      state_d        = state_q;
      round_d        = round_q;
      wcnt_d         = wcnt_q;
      st_d           = st_q;
      blk_d          = blk_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      feed_d         = feed_q;

      // Losing the keys mid-block means they are being regenerated: drop the block.
      if ((state_q != ST_IDLE) && !key_ready) begin
         state_d = ST_IDLE;
         round_d = 4'd0;
         wcnt_d  = 2'd0;
         feed_d  = 32'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && key_ready) begin
                  blk_d   = block;
                  round_d = 4'd0;
                  state_d = ST_INIT;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_INIT: begin
               st_d    = init_s;
               round_d = 4'd1;
               wcnt_d  = 2'd0;
               feed_d  = get_column(init_s, 2'd0);
               state_d = ST_SUB;
            end
            ST_SUB: begin
               // The S-box is looking at column wcnt_q via the feed register.
               st_d = set_column(st_q, wcnt_q, new_sbox);
               if (wcnt_q == 2'd3) begin
                  state_d = ST_MIX;
               end else begin
                  wcnt_d = wcnt_q + 2'd1;
                  feed_d = get_column(st_q, wcnt_q + 2'd1);
               end
            end
            ST_MIX: begin
               st_d = mix_s;
               if (final_round_s) begin
                  result_d       = mix_s;
                  result_valid_d = 1'b1;
                  round_d        = 4'd0;
                  feed_d         = 32'd0;
                  state_d        = ST_IDLE;
               end else begin
                  round_d = round_q + 4'd1;
                  wcnt_d  = 2'd0;
                  feed_d  = get_column(mix_s, 2'd0);
                  state_d = ST_SUB;
               end
            end
            default: begin
               state_d = ST_IDLE;
               round_d = 4'd0;
            end
         endcase
      end

      ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q        <= ST_IDLE;
         round_q        <= 4'd0;
         wcnt_q         <= 2'd0;
         st_q           <= 128'd0;
         blk_q          <= 128'd0;
         result_q       <= 128'd0;
         result_valid_q <= 1'b0;
         ready_q        <= 1'b1;
         feed_q         <= 32'd0;
      end else begin
         state_q        <= state_d;
         round_q        <= round_d;
         wcnt_q         <= wcnt_d;
         st_q           <= st_d;
         blk_q          <= blk_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         ready_q        <= ready_d;
         feed_q         <= feed_d;
      end
   end

   assign round        = round_q;
   assign ready        = ready_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign sbox_feed    = feed_q;

endmodule

// File: tb/tb_aes_encipher_round_ctrl.sv
// Self-checking bench: byte-level AES-128 reference with its own key schedule and
// S-box (derived from GF(2^8) inversion) driving the DUT's key and S-box ports.
module tb_aes_encipher_round_ctrl;

   logic         aclk;
   logic         aresetn;
   logic         key_ready;
   logic [3:0]   round;
   logic [127:0] round_key;
   logic         start;
   logic [127:0] block;
   logic         ready;
   logic [127:0] result;
   logic         result_valid;
   logic [31:0]  sbox_feed;
   logic [31:0]  new_sbox;

   logic [7:0]   sbox_tbl [0:255];
   logic [127:0] rk_mem [0:10];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_errors = 0;

   aes_encipher_round_ctrl dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .key_ready    (key_ready),
      .round        (round),
      .round_key    (round_key),
      .start        (start),
      .block        (block),
      .ready        (ready),
      .result       (result),
      .result_valid (result_valid),
      .sbox_feed    (sbox_feed),
      .new_sbox     (new_sbox)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   assign round_key = (round <= 4'd10) ? rk_mem[round] : 128'd0;
   assign new_sbox  = {sbox_tbl[sbox_feed[31:24]], sbox_tbl[sbox_feed[23:16]],
                       sbox_tbl[sbox_feed[15:8]],  sbox_tbl[sbox_feed[7:0]]};

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] round_key_of(input logic [127:0] key, input int r);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox_tbl[t[31:24]], sbox_tbl[t[23:16]], sbox_tbl[t[15:8]], sbox_tbl[t[7:0]]};
            t = t ^ {rcon, 24'h000000};
            rcon = gf_mul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
      logic [7:0]   s [0:15];
      logic [7:0]   t [0:15];
      logic [127:0] rk;
      logic [127:0] out;
      rk = round_key_of(key, 0);
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_tbl[s[i]];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[4*c+w] = s[4*((c+w)%4)+w];
         for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
               if (r < 10)
                  s[4*c+w] = gf_mul(8'h02, t[4*c+w]) ^ gf_mul(8'h03, t[4*c+(w+1)%4])
                           ^ t[4*c+(w+2)%4] ^ t[4*c+(w+3)%4];
               else
                  s[4*c+w] = t[4*c+w];
         rk = round_key_of(key, r);
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
      end
      out = 128'd0;
      for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
      return out;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic load_keys(input logic [127:0] key);
      for (int r = 0; r <= 10; r++) rk_mem[r] = round_key_of(key, r);
   endtask

   task automatic wait_valid(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge aclk);
         if (result_valid) break;
      end
      check_val({tag, "_valid_seen"}, 128'(result_valid), 128'd1);
   endtask

   task automatic wait_round(input logic [3:0] r);
      for (int i = 0; i < 100; i++) begin
         @(negedge aclk);
         if (round == r) break;
      end
      check_val("round_reached", 128'(round), 128'(r));
   endtask

   task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                            input logic [127:0] exp_ct, input string tag);
      int t0;
      @(negedge aclk);
      key_ready = 1'b0;
      load_keys(key);
      @(negedge aclk);
      key_ready = 1'b1;
      start     = 1'b1;
      block     = pt;
      @(posedge aclk);
      #1;
      start = 1'b0;
      t0 = cyc;
      @(negedge aclk);
      check_val({tag, "_busy_ready"}, 128'(ready), 128'd0);
      wait_valid(tag);
      check_val({tag, "_latency"}, 128'(cyc - t0), 128'd51);
      check_val({tag, "_ct"}, result, exp_ct);
      @(negedge aclk);
      check_val({tag, "_pulse"}, 128'(result_valid), 128'd0);
      check_val({tag, "_hold"}, result, exp_ct);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] k, p1, p2, prev;
      int t0, t1;
      logic bad_ready, bad_round, seen_valid;

      aresetn   = 1'b0;
      key_ready = 1'b0;
      start     = 1'b0;
      block     = 128'd0;
      build_sbox();
      load_keys(128'd0);

      repeat (3) @(negedge aclk);
      check_val("rst_round", 128'(round), 128'd0);
      check_val("rst_result", result, 128'd0);
      check_val("rst_valid", 128'(result_valid), 128'd0);
      check_val("rst_feed", 128'(sbox_feed), 128'd0);
      check_val("rst_ready", 128'(ready), 128'd1);
      aresetn = 1'b1;

      run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1");
      run_block(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, "appb");

      // start held high across two blocks
      k  = rand128();
      p1 = rand128();
      p2 = rand128();
      @(negedge aclk);
      key_ready = 1'b0;
      load_keys(k);
      @(negedge aclk);
      key_ready = 1'b1;
      start     = 1'b1;
      block     = p1;
      @(posedge aclk);
      #1;
      t0    = cyc;
      block = p2;
      wait_valid("b2b_first");
      t1 = cyc;
      check_val("b2b_first_lat", 128'(t1 - t0), 128'd51);
      check_val("b2b_first_ct", result, aes_ref(k, p1));
      wait_valid("b2b_second");
      start = 1'b0;
      check_val("b2b_second_gap", 128'(cyc - t1), 128'd52);
      check_val("b2b_second_ct", result, aes_ref(k, p2));

      // key store drops at round 5
      prev = result;
      @(negedge aclk);
      start = 1'b1;
      block = rand128();
      @(posedge aclk);
      #1;
      start = 1'b0;
      wait_round(4'd5);
      key_ready = 1'b0;
      @(negedge aclk);
      check_val("abort_ready", 128'(ready), 128'd1);
      check_val("abort_round", 128'(round), 128'd0);
      check_val("abort_result", result, prev);
      seen_valid = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge aclk);
         start = (i % 7 == 0);
         if (result_valid) seen_valid = 1'b1;
      end
      start = 1'b0;
      check_val("abort_no_valid", 128'(seen_valid), 128'd0);
      check_val("abort_result_kept", result, prev);

      // reset mid-operation
      @(negedge aclk);
      key_ready = 1'b1;
      start     = 1'b1;
      block     = rand128();
      @(posedge aclk);
      #1;
      start = 1'b0;
      wait_round(4'd3);
      aresetn = 1'b0;
      #1;
      check_val("arst_round", 128'(round), 128'd0);
      check_val("arst_result", result, 128'd0);
      check_val("arst_valid", 128'(result_valid), 128'd0);
      check_val("arst_feed", 128'(sbox_feed), 128'd0);
      check_val("arst_ready", 128'(ready), 128'd1);
      @(negedge aclk);
      aresetn = 1'b1;
      run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, "c1_after_rst");

      // start without keys is ignored
      prev = result;
      key_ready  = 1'b0;
      start      = 1'b1;
      bad_ready  = 1'b0;
      bad_round  = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         block = rand128();
         @(negedge aclk);
         if (ready !== 1'b1) bad_ready = 1'b1;
         if (round !== 4'd0) bad_round = 1'b1;
         if (result_valid) seen_valid = 1'b1;
      end
      start = 1'b0;
      check_val("nokey_ready", 128'(bad_ready), 128'd0);
      check_val("nokey_round", 128'(bad_round), 128'd0);
      check_val("nokey_valid", 128'(seen_valid), 128'd0);
      check_val("nokey_result", result, prev);

      for (int n = 0; n < 6; n++) begin
         k  = rand128();
         p1 = rand128();
         run_block(k, p1, aes_ref(k, p1), "rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
